divider: RTL and testbench

- Fixed-point signed divider; the inverse of the audio multiplier. The multiplier computes out = (in1*in2) >> BITSIZE.
- This block computes out = (in1 << BITSIZE) / in2, truncated toward zero and saturated, so that multiplying the result by in2 gives in1 back.
- Iterative restoring division, one quotient bit per clock, start/done handshake.
- Used for gain normalisation and envelope ratio computation on the audio clock.

---
 rtl/divider.sv | 145 ++++++++++++++
 tb/tb_divider.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Signed fixed-point divider: out = (in1 << BITSIZE) / in2, truncated and saturated.
// Restoring division, one quotient bit per clock, start/done handshake.
module divider #(
    parameter int BITSIZE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BITSIZE-1:0] in1,
    input  logic [BITSIZE-1:0] in2,
    output logic               busy,
    output logic               done,
    output logic [BITSIZE-1:0] out,
    output logic               saturated,
    output logic               div_by_zero
);

    localparam int CW = $clog2(BITSIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(BITSIZE - 1);
    localparam logic [BITSIZE-1:0] MAXV = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] MINV = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, ITER, FINISH} state_t;
    typedef logic [BITSIZE:0] mag_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [BITSIZE-1:0] a, b;
    logic [BITSIZE-1:0] q;
    mag_t               rem, dvs;
    logic               neg, ovf, exact, dbz, a_neg;

    mag_t               ext_a, ext_b, abs_a, abs_b;
    logic [BITSIZE+1:0] rem2;
    logic [BITSIZE-1:0] res;
    logic               res_sat;

    // Magnitudes need one extra bit so the most negative value fits.
    always_comb begin
        ext_a = {a[BITSIZE-1], a};
        ext_b = {b[BITSIZE-1], b};
        abs_a = a[BITSIZE-1] ? -ext_a : ext_a;
        abs_b = b[BITSIZE-1] ? -ext_b : ext_b;
        rem2  = {rem, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = ITER;
            ITER:    if (cnt == LAST) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Exact half-range quotient is representable only as a negative result.
    always_comb begin
        busy    = (state != IDLE);
        res     = q;
        res_sat = 1'b0;
        if (dbz) begin
            res     = a_neg ? MINV : MAXV;
            res_sat = 1'b1;
        end else if (!neg) begin
            if (ovf || q > MAXV) begin
                res     = MAXV;
                res_sat = 1'b1;
            end
        end else if (exact) begin
            res = MINV;
        end else if (ovf || q > MINV) begin
            res     = MINV;
            res_sat = 1'b1;
        end else begin
            res = -q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            a           <= '0;
            b           <= '0;
            q           <= '0;
            rem         <= '0;
            dvs         <= '0;
            neg         <= 1'b0;
            ovf         <= 1'b0;
            exact       <= 1'b0;
            dbz         <= 1'b0;
            a_neg       <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
            saturated   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a <= in1;
                        b <= in2;
                    end
                end
                PREP: begin
                    cnt   <= '0;
                    q     <= '0;
                    rem   <= abs_a;
                    dvs   <= abs_b;
                    neg   <= a[BITSIZE-1] ^ b[BITSIZE-1];
                    a_neg <= a[BITSIZE-1];
                    ovf   <= ({abs_a, 1'b0} >= {1'b0, abs_b});
                    exact <= ({abs_a, 1'b0} == {1'b0, abs_b});
                    dbz   <= (b == '0);
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (rem2 >= {1'b0, dvs}) begin
                        rem <= mag_t'(rem2 - {1'b0, dvs});
                        q   <= {q[BITSIZE-2:0], 1'b1};
                    end else begin
                        rem <= mag_t'(rem2);
                        q   <= {q[BITSIZE-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    done        <= 1'b1;
                    out         <= res;
                    saturated   <= res_sat;
                    div_by_zero <= dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Randomized scoreboard bench for divider (BITSIZE=16).
// Expected results come from plain integer division of (in1 << 16) by in2.
module tb_divider;

    localparam int W = 16;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] out;
        logic         sat;
        logic         dbz;
        int           t0;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done, saturated, div_by_zero;
    logic [W-1:0] out;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    exp_t e;

    divider #(.BITSIZE(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in1(in1),
        .in2(in2),
        .busy(busy),
        .done(done),
        .out(out),
        .saturated(saturated),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int t0);
        exp_t   r;
        longint n, d, qv, rv;
        r.t0  = t0;
        r.a   = a;
        r.b   = b;
        r.sat = 1'b0;
        r.dbz = 1'b0;
        n = longint'($signed(a)) * 65536;
        d = longint'($signed(b));
        if (d == 0) begin
            r.dbz = 1'b1;
            r.sat = 1'b1;
            r.out = (n >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            qv = n / d;
            rv = n % d;
            if (qv > 32767) begin
                r.out = 16'h7FFF;
                r.sat = 1'b1;
            end else if (qv < -32768 || (qv == -32768 && rv != 0)) begin
                r.out = 16'h8000;
                r.sat = 1'b1;
            end else begin
                r.out = 16'(qv);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                check($sformatf("out(%h/%h)", e.a, e.b), 32'(out), 32'(e.out));
                check($sformatf("sat(%h/%h)", e.a, e.b), 32'(saturated), 32'(e.sat));
                check($sformatf("dbz(%h/%h)", e.a, e.b), 32'(div_by_zero), 32'(e.dbz));
                check("latency", 32'(cyc - e.t0), 32'(LAT));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            if (!hold) begin
                in1   = 16'($urandom);
                in2   = 16'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            n++;
            @(negedge clk);
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: got busy=1 expected idle within 100 cycles");
            return;
        end
        in1   = a;
        in2   = b;
        start = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        start = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           sel;
        bit           hold;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_sat", 32'(saturated), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        issue(16'h1000, 16'h4000, 1'b0);
        issue(16'hF000, 16'h4000, 1'b0);
        issue(16'h1000, 16'hC000, 1'b0);
        issue(16'hE000, 16'h4000, 1'b0);
        issue(16'h2000, 16'h4000, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0);
        issue(16'h0001, 16'h8000, 1'b0);
        issue(16'h0001, 16'h0003, 1'b0);
        issue(16'hFFFF, 16'h0003, 1'b0);
        issue(16'h0005, 16'h0000, 1'b0);
        issue(16'hFFFB, 16'h0000, 1'b0);
        issue(16'h1000, 16'h4000, 1'b0);

        issue(16'h0100, 16'h0300, 1'b1);
        issue(16'h8000, 16'h8000, 1'b1);
        issue(16'hC000, 16'h8000, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            sel = $urandom_range(0, 5);
            if (sel < 3) ra = 16'($signed(ra) >>> $urandom_range(2, 10));
            if (sel == 5) rb = '0;
            hold = ($urandom_range(0, 3) == 0);
            issue(ra, rb, hold);
        end
        drain();

        issue(16'h0300, 16'h0700, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_out", 32'(out), 32'd0);
        check("arst_sat", 32'(saturated), 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        issue(16'hF000, 16'h4000, 1'b0);
        issue(16'h0005, 16'h0000, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
